dma_bus_master: RTL
===================

// Module: dma_bus_master
// PURPOSE
//  Bus-side transfer engine placed directly downstream of the DMA custom-instruction controller.
//  The controller latches the transfer registers (bus address, memory address, block size,
//  burst size, control) and pulses start. This block then moves the block between the shared
//  bus and the 512x32 on-chip DMA buffer as a series of bursts, re-arbitrating for every burst.
//  On completion it reports done, busy and error back to the controller.
// PARAMETERS
//  MEM_AW      9    on-chip buffer word-address width (512 words)
//  BLOCK_W     10   block-size counter width, in words (max 1023)
// PORTS
//  clock              in   1   system clock
//  reset              in   1   asynchronous, active-low reset
//  cfg_start          in   1   1-cycle pulse: latch cfg_* and begin transfer
//  cfg_dir            in   1   0 = bus->buffer (bus read); 1 = buffer->bus (bus write)
//  cfg_bus_addr       in   32  word-aligned bus start address
//  cfg_mem_addr       in   9   buffer start word address
//  cfg_block_size     in   10  number of words to move
//  cfg_burst_size     in   8   burst length - 1 (0 = single word)
//  busy               out  1   transfer in progress
//  done               out  1   1-cycle pulse at end of transfer, normal or aborted
//  error              out  1   sticky bus error; cleared by next accepted cfg_start
//  bus_request        out  1   arbitration request
//  bus_grant          in   1   arbitration grant
//  begin_transaction_out, end_transaction_out, data_valid_out, read_n_write_out  out 1  bus ctrl
//  address_data_out   out  32  address in begin cycle, write data otherwise
//  byte_enables_out   out  4   always 4'hF while driving; otherwise 0
//  burst_size_out     out  8   words-in-burst - 1, valid in begin cycle
//  address_data_in    in   32  read data
//  end_transaction_in, data_valid_in, busy_in, error_in  in 1  slave responses
//  mem_addr           out  9   buffer word address
//  mem_we             out  1   buffer write strobe
//  mem_wdata          out  32  buffer write data
//  mem_rdata          in   32  buffer read data; 1-cycle latency after mem_addr
// BEHAVIOUR
//  - Reset: every output is 0; FSM in IDLE; counters cleared.
//  - cfg_start in IDLE latches all cfg_* fields and clears error. cfg_start in any other state
//    is ignored. A block size of 0 pulses done on the next cycle without requesting the bus.
//  - FSM states: IDLE -> REQ -> BEGIN -> {RD | WR} -> END -> (REQ if remaining>0 else DONE) -> IDLE.
//    ERR is entered from RD/WR on error_in and returns to IDLE.
//  - REQ: bus_request=1 until the burst ends. BEGIN is entered on the first cycle with bus_grant=1.
//  - BEGIN (1 cycle): begin_transaction_out=1, address_data_out=current bus addr,
//    burst_size_out=min(cfg_burst_size+1, remaining)-1, read_n_write_out=~cfg_dir.
//  - RD: each data_valid_in writes address_data_in to mem_addr (mem_we=1) and then increments
//    mem_addr and decrements remaining. end_transaction_in moves to END.
//  - WR: the buffer word is prefetched one cycle early. A one-entry holding register keeps
//    data_valid_out/address_data_out stable while busy_in=1; the word advances only on
//    data_valid_out & ~busy_in. After the last word, end_transaction_out=1 for 1 cycle -> END.
//  - END: bus_request drops for at least 1 cycle; bus addr += 4*words_in_burst.
//  - error_in in RD/WR: the burst is abandoned, end_transaction_out=1 for 1 cycle (WR only),
//    bus_request drops, error=1, done pulses, and no further bursts are issued.
//  - Buffer address wraps modulo 512. The bus address wraps modulo 2^32 with no error.
//  - busy = (state != IDLE). done coincides with the DONE/ERR exit cycle.
//  - Reset mid-transfer drops all bus outputs immediately; no end_transaction is issued.
// STRUCTURE
//  - A shared dma_pkg holds: FSM state encoding; the DIR_READ/DIR_WRITE constants; the
//    BYTE_EN_WORD=4'hF constant.
//  - One sub-module, dma_burst_counter: tracks remaining words and words-in-burst, and
//    produces last_in_burst and last_in_block.
// TESTING
//  - read, bus=0x1000, mem=0, size=8, burst=3, immediate grant -> 2 bursts, burst_size_out=3 each,
//    begin addresses 0x1000 then 0x1010, buffer[0..7] written, single done.
//  - write, size=5, burst=3 -> bursts of 4 then 1 (burst_size_out=3, then 0); data on bus matches
//    buffer[0..4]; busy_in held 3 cycles mid-burst -> no word lost or duplicated.
//  - size=0 -> done 1 cycle after start; bus_request never asserted.
//  - read with error_in on 2nd word -> error=1, done pulse, no further begin_transaction_out,
//    error cleared by the next start.
//  - mem=0x1FE, size=4 -> buffer addresses 0x1FE, 0x1FF, 0x000, 0x001.
//  - grant withheld 20 cycles; cfg_start re-pulsed while busy -> waits with request held, second
//    start ignored; reset mid-burst -> all outputs 0 next edge.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA bus-side transfer engine.
package dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_BEGIN,
      ST_RD,
      ST_WR,
      ST_END,
      ST_DONE,
      ST_ERR
   } dma_state_t;

   localparam logic       DIR_READ     = 1'b0;
   localparam logic       DIR_WRITE    = 1'b1;
   localparam logic [3:0] BYTE_EN_WORD = 4'hF;

endpackage

// File: rtl/dma_burst_counter.sv
// Tracks words left in the block and in the current burst.
module dma_burst_counter #(
   parameter int BLOCK_W = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_block,
   input  logic [BLOCK_W-1:0] block_size,
   input  logic               load_burst,
   input  logic [7:0]         burst_cfg,
   input  logic               dec,
   output logic [8:0]         burst_words,
   output logic               last_in_burst,
   output logic               last_in_block,
   output logic               block_empty
);

   logic [BLOCK_W-1:0] remaining;
   logic [8:0]         burst_left;
   logic [8:0]         burst_len;
   logic [8:0]         words_next;

   // Next burst length is the configured burst clipped to what is left in the block.
   always_comb begin
      burst_len  = {1'b0, burst_cfg} + 9'd1;
      words_next = burst_len;
      if (BLOCK_W'(burst_len) > remaining) begin
         words_next = remaining[8:0];
      end
   end

   // Block and burst word counters; both only ever count down.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         remaining   <= '0;
         burst_left  <= '0;
         burst_words <= '0;
      end else if (load_block) begin
         remaining   <= block_size;
         burst_left  <= '0;
         burst_words <= '0;
      end else if (load_burst) begin
         burst_left  <= words_next;
         burst_words <= words_next;
      end else if (dec) begin
         remaining  <= remaining - 1'b1;
         burst_left <= burst_left - 9'd1;
      end
   end

   assign last_in_burst = (burst_left == 9'd1);
   assign last_in_block = (remaining == BLOCK_W'(1));
   assign block_empty   = (remaining == '0);

endmodule

// File: rtl/dma_bus_master.sv
// Moves a block between the shared bus and the on-chip DMA buffer as re-arbitrated bursts.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for cfg_start
// REQ      | requesting the bus for the next burst
// BEGIN    | address / burst-length cycle
// RD       | bus read burst, data written into the buffer
// WR       | bus write burst, buffer data driven on the bus
// END      | burst closed, request dropped, address advanced
// DONE     | block complete, done pulse
// ERR      | bus error, burst abandoned, done pulse
module dma_bus_master
   import dma_pkg::*;
#(
   parameter int MEM_AW  = 9,
   parameter int BLOCK_W = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cfg_start,
   input  logic               cfg_dir,
   input  logic [31:0]        cfg_bus_addr,
   input  logic [MEM_AW-1:0]  cfg_mem_addr,
   input  logic [BLOCK_W-1:0] cfg_block_size,
   input  logic [7:0]         cfg_burst_size,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic               bus_request,
   input  logic               bus_grant,
   output logic               begin_transaction_out,
   output logic               end_transaction_out,
   output logic               data_valid_out,
   output logic               read_n_write_out,
   output logic [31:0]        address_data_out,
   output logic [3:0]         byte_enables_out,
   output logic [7:0]         burst_size_out,
   input  logic [31:0]        address_data_in,
   input  logic               end_transaction_in,
   input  logic               data_valid_in,
   input  logic               busy_in,
   input  logic               error_in,
   output logic [MEM_AW-1:0]  mem_addr,
   output logic               mem_we,
   output logic [31:0]        mem_wdata,
   input  logic [31:0]        mem_rdata
);

   dma_state_t        state, state_nxt;
   logic              dir_q;
   logic [31:0]       bus_addr_q;
   logic [MEM_AW-1:0] mem_ptr;
   logic [7:0]        burst_cfg_q;
   logic              error_q;
   logic [31:0]       hold_q;
   logic              hold_valid;
   logic              fetch_pend;

   logic [8:0]        burst_words;
   logic [8:0]        burst_m1;
   logic              last_in_burst, last_in_block, block_empty;
   logic              start_ok, load_burst, rd_take, accept, fetch, dec;
   logic              wr_src_valid;
   logic [31:0]       wr_data;

   assign start_ok     = (state == ST_IDLE) && cfg_start;
   assign load_burst   = (state == ST_REQ) && bus_grant;
   assign rd_take      = (state == ST_RD) && data_valid_in && !error_in;
   // The word on the bus comes from the holding register if a stall parked it there,
   // otherwise straight from the buffer read issued last cycle.
   assign wr_src_valid = hold_valid || fetch_pend;
   assign wr_data      = hold_valid ? hold_q : mem_rdata;
   assign accept       = (state == ST_WR) && wr_src_valid && !busy_in;
   assign fetch        = ((state == ST_BEGIN) && (dir_q == DIR_WRITE)) ||
                         (accept && !last_in_burst && !last_in_block);
   assign dec          = rd_take || accept;
   assign burst_m1     = burst_words - 9'd1;

   assign busy     = (state != ST_IDLE);
   assign error    = error_q;
   assign mem_addr = mem_ptr;

   dma_burst_counter #(.BLOCK_W(BLOCK_W)) u_cnt (
      .clock         (clock),
      .reset         (reset),
      .load_block    (start_ok),
      .block_size    (cfg_block_size),
      .load_burst    (load_burst),
      .burst_cfg     (burst_cfg_q),
      .dec           (dec),
      .burst_words   (burst_words),
      .last_in_burst (last_in_burst),
      .last_in_block (last_in_block),
      .block_empty   (block_empty)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and bus/buffer output decode.
   always_comb begin
      state_nxt             = state;
      bus_request           = 1'b0;
      begin_transaction_out = 1'b0;
      end_transaction_out   = 1'b0;
      data_valid_out        = 1'b0;
      read_n_write_out      = 1'b0;
      address_data_out      = '0;
      byte_enables_out      = '0;
      burst_size_out        = '0;
      mem_we                = 1'b0;
      mem_wdata             = '0;
      done                  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cfg_start) state_nxt = (cfg_block_size == '0) ? ST_DONE : ST_REQ;
         end
         ST_REQ: begin
            bus_request = 1'b1;
            if (bus_grant) state_nxt = ST_BEGIN;
         end
         ST_BEGIN: begin
            bus_request           = 1'b1;
            begin_transaction_out = 1'b1;
            address_data_out      = bus_addr_q;
            burst_size_out        = burst_m1[7:0];
            read_n_write_out      = ~dir_q;
            byte_enables_out      = BYTE_EN_WORD;
            state_nxt             = (dir_q == DIR_WRITE) ? ST_WR : ST_RD;
         end
         ST_RD: begin
            bus_request = 1'b1;
            mem_we      = rd_take;
            if (rd_take) mem_wdata = address_data_in;
            if (error_in)                state_nxt = ST_ERR;
            else if (end_transaction_in) state_nxt = ST_END;
         end
         ST_WR: begin
            bus_request    = 1'b1;
            data_valid_out = wr_src_valid;
            if (wr_src_valid) begin
               address_data_out = wr_data;
               byte_enables_out = BYTE_EN_WORD;
            end
            if (error_in)                     state_nxt = ST_ERR;
            else if (accept && last_in_burst) state_nxt = ST_END;
         end
         ST_END: begin
            end_transaction_out = (dir_q == DIR_WRITE);
            state_nxt           = block_empty ? ST_DONE : ST_REQ;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_ERR: begin
            done                = 1'b1;
            end_transaction_out = (dir_q == DIR_WRITE);
            state_nxt           = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Transfer context: latched config, running addresses, sticky error.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dir_q       <= DIR_READ;
         bus_addr_q  <= '0;
         mem_ptr     <= '0;
         burst_cfg_q <= '0;
         error_q     <= 1'b0;
      end else begin
         if (start_ok) begin
            dir_q       <= cfg_dir;
            bus_addr_q  <= cfg_bus_addr;
            burst_cfg_q <= cfg_burst_size;
            error_q     <= 1'b0;
         end else if (state == ST_END) begin
            bus_addr_q <= bus_addr_q + {21'b0, burst_words, 2'b00};
         end
         if (start_ok)              mem_ptr <= cfg_mem_addr;
         else if (rd_take || fetch) mem_ptr <= mem_ptr + 1'b1;
         if (((state == ST_RD) || (state == ST_WR)) && error_in) error_q <= 1'b1;
      end
   end

   // Write-side prefetch: parks the fetched word while the slave stalls.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pend <= 1'b0;
         hold_valid <= 1'b0;
         hold_q     <= '0;
      end else begin
         fetch_pend <= fetch;
         if (state != ST_WR) begin
            hold_valid <= 1'b0;
         end else if (accept) begin
            hold_valid <= 1'b0;
         end else if (fetch_pend && !hold_valid) begin
            hold_q     <= mem_rdata;
            hold_valid <= 1'b1;
         end
      end
   end

endmodule
